// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int              UART_DATA_W   = 8;
    localparam logic [7:0]      UART_NL       = 8'h0A;
    localparam int              UART_LOCK_TMO = 256;

endpackage

// File: rtl/uart_tx_ser.sv
// Frame serializer: start bit, 8 data bits LSB first, stop bit, each bc+1 clocks.
module uart_tx_ser
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [UART_DATA_W-1:0] ch_i,
    input  logic [15:0]            bc_i,
    output logic                   tx_o,
    output logic                   busy_o
);

    uart_state_e            state_q, state_d;
    logic [15:0]            tmr_q, tmr_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] sh_q, sh_d;
    logic [15:0]            bc_q, bc_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;

    // Equality compare keeps bc=16'hFFFF from wrapping the timer.
    assign bit_end = (tmr_q == bc_q);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        bc_d    = bc_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = START;
                    tmr_d   = '0;
                    idx_d   = '0;
                    sh_d    = ch_i;
                    bc_d    = bc_i;
                end
            end
            START: begin
                if (bit_end) begin
                    tmr_d   = '0;
                    state_d = DATA;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tmr_d = '0;
                    if (idx_q == 3'(UART_DATA_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = sh_q >> 1;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so tx switches on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = sh_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
        bc_q <= bc_d;
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin UART transmitter; define UART_TX_ARB_LINE_LOCK_EN
// to hold the grant on one requester until it sends a newline (or times out).
module uart_tx_arb
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bc,
    input  logic        req0_vld,
    input  logic [7:0]  req0_ch,
    output logic        req0_rdy,
    input  logic        req1_vld,
    input  logic [7:0]  req1_ch,
    output logic        req1_rdy,
    output logic        tx,
    output logic        busy
);

    logic                   last_q, last_d;
    logic                   elig0, elig1;
    logic                   gnt;
    logic                   xfer;
    logic [UART_DATA_W-1:0] ch_sel;

`ifdef UART_TX_ARB_LINE_LOCK_EN
    logic       lock_q, lock_d;
    logic       own_q, own_d;
    logic       own_vld;
    logic [7:0] tmo_q, tmo_d;

    assign own_vld = own_q ? req1_vld : req0_vld;
    assign elig0   = req0_vld && !(lock_q && own_q);
    assign elig1   = req1_vld && !(lock_q && !own_q);

    // Timeout counts only consecutive idle cycles in which the lock owner has nothing to send.
    always_comb begin
        lock_d = lock_q;
        own_d  = own_q;
        tmo_d  = '0;
        if (xfer) begin
            if (ch_sel != UART_NL) begin
                lock_d = 1'b1;
                own_d  = gnt;
            end else begin
                lock_d = 1'b0;
            end
        end else if (lock_q && !busy && !own_vld) begin
            if (tmo_q == 8'(UART_LOCK_TMO - 1)) begin
                lock_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
            own_q  <= 1'b0;
            tmo_q  <= '0;
        end else begin
            lock_q <= lock_d;
            own_q  <= own_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    assign elig0 = req0_vld;
    assign elig1 = req1_vld;
`endif

    always_comb begin
        gnt = elig1;
        if (elig0 && elig1) begin
            gnt = ~last_q;
        end
    end

    assign req0_rdy = !busy && !rst && elig0 && !gnt;
    assign req1_rdy = !busy && !rst && elig1 && gnt;
    assign xfer     = req0_rdy || req1_rdy;
    assign ch_sel   = gnt ? req1_ch : req0_ch;
    assign last_d   = xfer ? gnt : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    uart_tx_ser u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (xfer),
        .ch_i   (ch_sel),
        .bc_i   (bc),
        .tx_o   (tx),
        .busy_o (busy)
    );

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous assert, active-high.
REQ-003 SHALL have ports: bc  in  16  baud count; each bit lasts bc+1 clk cycles.
REQ-004 SHALL have ports: req0_vld  in  1  requester 0 has a character.
REQ-005 SHALL have ports: req0_ch  in  8  requester 0 character.
REQ-006 SHALL have ports: req0_rdy  out  1  requester 0 character accepted this cycle.
REQ-007 SHALL have ports: req1_vld, req1_ch, req1_rdy, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have ports: tx  out  1  serial line, idle high.
REQ-009 SHALL have ports: busy  out  1  frame in progress (state != IDLE).

Function
REQ-010 SHALL run a frame FSM with states IDLE, START, DATA, STOP.
REQ-011 SHALL transfer in IDLE only; transfer = reqN_vld && reqN_rdy.
REQ-012 SHALL drive reqN_rdy combinationally high in IDLE only for the granted requester with vld set; at most one rdy is high per cycle.
REQ-013 SHALL arbitrate round-robin: if both valid, grant the requester not served last; if one is valid, grant it.
REQ-014 SHALL take the last-served pointer after reset as requester 1, so requester 0 wins the first tie.
REQ-015 SHALL latch ch and bc on transfer, then enter START next cycle; later bc changes SHALL NOT affect the current frame.
REQ-016 SHALL drive tx low for bc+1 cycles in START.
REQ-017 SHALL send 8 data bits in DATA, LSB first, bc+1 cycles each.
REQ-018 SHALL hold tx high for bc+1 cycles in STOP, then return to IDLE.
REQ-019 SHALL make a frame last 10*(bc+1) cycles from START entry to IDLE entry.
REQ-020 SHALL, for back-to-back characters, keep one IDLE cycle (tx high) between frames.
REQ-021 SHALL use a 16-bit bit-timer counting 0..bc and a 3-bit data-bit index; bc=0 gives 1 cycle per bit; bc=16'hFFFF SHALL NOT overflow (counter compares for equality).
REQ-022 SHALL register tx, which SHALL be glitch-free.
REQ-023 SHALL ignore vld deassertion by a requester while not in IDLE.

Reset
REQ-024 SHALL force on rst: state IDLE, tx=1, busy=0, req0_rdy=req1_rdy=0 (while rst is high), bit timer=0, bit index=0, last-served=1, lock cleared.
REQ-025 SHALL abort any frame in progress when reset is asserted mid-frame; tx SHALL go high immediately (asynchronously), and the partial character SHALL NOT be retransmitted.

Configuration
REQ-026 SHALL compile line locking in when macro UART_TX_ARB_LINE_LOCK_EN is defined.
REQ-027 SHALL, with the macro defined: a transfer with ch != 8'h0A locks the grant to that requester; a transfer with ch == 8'h0A releases the lock; while locked, the other requester SHALL NOT be granted.
REQ-028 SHALL, with the macro defined, release the lock after 256 consecutive IDLE cycles without the locked requester's vld (8-bit timeout counter).
REQ-029 SHALL, without the macro, arbitrate pure round-robin per character and omit the lock and timeout logic entirely.

Structure
REQ-030 SHALL define in package uart_pkg: state enum (IDLE/START/DATA/STOP), UART_DATA_W=8, UART_NL=8'h0A, UART_LOCK_TMO=256.
REQ-031 SHALL contain one sub-module, uart_tx_ser, holding the FSM, bit timer and shifter; uart_tx_arb SHALL hold the arbiter and lock logic.

Verification
REQ-032 SHALL cover: bc=9, req0 sends 8'h41 -> tx low 10 cycles, then bits 1,0,0,0,0,0,1,0 at 10 cycles each, high 10; busy high 100 cycles; req0_rdy high exactly 1 cycle.
REQ-033 SHALL cover: both valid every cycle, bc=0, req0 "AB", req1 "xy" -> line order A,x,B,y; frame period 11 cycles.
REQ-034 SHALL cover: bc changed 9->3 mid-frame -> current frame keeps 10-cycle bits; next frame uses 4-cycle bits.
REQ-035 SHALL cover: rst asserted at cycle 35 of a frame -> tx=1 same cycle; after release, next req1 character is sent complete and correct.
REQ-036 SHALL cover, with UART_TX_ARB_LINE_LOCK_EN: req0 "hi\n", req1 "ok\n", both valid -> output "hi\nok\n"; without the macro -> "hoik\n\n".
REQ-037 SHALL cover, with UART_TX_ARB_LINE_LOCK_EN: req0 sends "h" then drops vld, req1 valid -> req1 granted on the 257th IDLE cycle after req0's frame.
